// File: rtl/udp_dispatch_pkg.sv
// udp_rx_dispatch shared types: write/read FSM states and the
// committed-frame descriptor {len, idx}, sized for the widest build.
package udp_dispatch_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_RECV,
    W_WAIT_KILL,
    W_DROP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_SEND
  } rd_state_t;

  localparam int LEN_W = 16;
  localparam int IDX_W = 8;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [IDX_W-1:0] idx;
  } desc_t;

endpackage

// File: rtl/dispatch_meta_fifo.sv
// Descriptor FIFO for committed frames.
// Ports: clk, rst (async low), push/din, pop/dout (head), full, empty.
module dispatch_meta_fifo
  import udp_dispatch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  desc_t din,
  input  logic  pop,
  output desc_t dout,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  desc_t       mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;

  assign full  = (wp - rp) == CAP;
  assign empty = wp == rp;
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + ONE;
      if (pop && !empty) rp <= rp + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/udp_rx_dispatch.sv
// Buffers udp_rx payload frames, commits/rolls back on kill, tags each
// with a port-table consumer index and drains them over valid/ready.
// In: s_axiiv/s_axiid/dst_port_in/kill, cfg_* table writes, m_axior.
// Out: m_axiov/m_axiod/m_last/m_idx, busy.
// UDP_DISPATCH_STATS_EN adds drop_kill_cnt/drop_nomatch_cnt/drop_ovf_cnt.
module udp_rx_dispatch
  import udp_dispatch_pkg::*;
#(
  parameter int N          = 4,
  parameter int DEPTH      = 256,
  parameter int NUM_PORTS  = 4,
  parameter int META_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_axiiv,
  input  logic [N-1:0]                 s_axiid,
  input  logic [15:0]                  dst_port_in,
  input  logic                         kill,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_PORTS)-1:0] cfg_idx,
  input  logic [15:0]                  cfg_port,
  input  logic                         cfg_en,
  output logic                         m_axiov,
  output logic [N-1:0]                 m_axiod,
  output logic                         m_last,
  output logic [$clog2(NUM_PORTS)-1:0] m_idx,
  input  logic                         m_axior,
`ifdef UDP_DISPATCH_STATS_EN
  output logic [15:0]                  drop_kill_cnt,
  output logic [15:0]                  drop_nomatch_cnt,
  output logic [15:0]                  drop_ovf_cnt,
`endif
  output logic                         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = AW + 1;
  localparam int IW = $clog2(NUM_PORTS);
  localparam logic [PW-1:0] CAP  = PW'(DEPTH);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [LW-1:0] LONE = LW'(1);
  localparam logic [LW-1:0] LTWO = LW'(2);

  logic [N-1:0]  buf_mem [DEPTH];
  logic [15:0]   tbl_port [NUM_PORTS];
  logic [NUM_PORTS-1:0] tbl_en;

  wr_state_t     wr_st;
  rd_state_t     rd_st;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] commit_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_nx;
  logic [LW-1:0] len;
  logic [LW-1:0] rem;
  logic [IW-1:0] wr_idx;

  logic          buf_full;
  logic          hit;
  logic [IW-1:0] hit_idx;
  logic          accept;
  logic          wr_en;

  desc_t         meta_din;
  desc_t         meta_dout;
  logic          meta_push;
  logic          meta_pop;
  logic          meta_full;
  logic          meta_empty;
  logic          unused_desc;

  assign buf_full = (wr_ptr - rd_ptr) == CAP;
  assign rd_nx    = rd_ptr + PONE;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (tbl_en[i] && tbl_port[i] == dst_port_in) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign accept = hit && !meta_full && !buf_full;
  assign wr_en  = s_axiiv &&
                  ((wr_st == W_IDLE && accept) ||
                   (wr_st == W_RECV && !buf_full));

  assign meta_push    = (wr_st == W_WAIT_KILL) && !kill;
  assign meta_din.len = LEN_W'(len);
  assign meta_din.idx = IDX_W'(wr_idx);

  // A descriptor is retired only after its last beat leaves, so the
  // FIFO occupancy counts every committed frame not yet drained.
  assign meta_pop = (rd_st == R_SEND) && m_axior && m_last;

  assign unused_desc = ^{meta_dout.len[LEN_W-1:LW],
                         meta_dout.idx[IDX_W-1:IW]};

  assign busy = (wr_st != W_IDLE) || !meta_empty;

  dispatch_meta_fifo #(
    .DEPTH(META_DEPTH)
  ) u_meta (
    .clk  (clk),
    .rst  (rst),
    .push (meta_push),
    .din  (meta_din),
    .pop  (meta_pop),
    .dout (meta_dout),
    .full (meta_full),
    .empty(meta_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tbl_en <= '0;
      for (int i = 0; i < NUM_PORTS; i++) tbl_port[i] <= '0;
    end else if (cfg_we) begin
      tbl_port[cfg_idx] <= cfg_port;
      tbl_en[cfg_idx]   <= cfg_en;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[wr_ptr[AW-1:0]] <= s_axiid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_st      <= W_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      len        <= '0;
      wr_idx     <= '0;
    end else begin
      unique case (wr_st)
        W_IDLE: begin
          if (s_axiiv) begin
            if (accept) begin
              wr_ptr <= wr_ptr + PONE;
              len    <= LONE;
              wr_idx <= hit_idx;
              wr_st  <= W_RECV;
            end else begin
              wr_st <= W_DROP;
            end
          end
        end
        W_RECV: begin
          if (s_axiiv) begin
            if (buf_full) begin
              wr_ptr <= commit_ptr;
              wr_st  <= W_DROP;
            end else begin
              wr_ptr <= wr_ptr + PONE;
              len    <= len + LONE;
            end
          end else begin
            wr_st <= W_WAIT_KILL;
          end
        end
        W_WAIT_KILL: begin
          if (kill) wr_ptr     <= commit_ptr;
          else      commit_ptr <= wr_ptr;
          wr_st <= s_axiiv ? W_DROP : W_IDLE;
        end
        W_DROP: begin
          if (!s_axiiv) wr_st <= W_IDLE;
        end
        default: wr_st <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_st   <= R_IDLE;
      rd_ptr  <= '0;
      rem     <= '0;
      m_axiov <= 1'b0;
      m_axiod <= '0;
      m_last  <= 1'b0;
      m_idx   <= '0;
    end else begin
      unique case (rd_st)
        R_IDLE: begin
          if (!meta_empty) begin
            rem     <= meta_dout.len[LW-1:0];
            m_idx   <= meta_dout.idx[IW-1:0];
            m_axiod <= buf_mem[rd_ptr[AW-1:0]];
            m_last  <= meta_dout.len[LW-1:0] == LONE;
            m_axiov <= 1'b1;
            rd_st   <= R_SEND;
          end
        end
        R_SEND: begin
          if (m_axior) begin
            rd_ptr <= rd_nx;
            if (m_last) begin
              m_axiov <= 1'b0;
              m_last  <= 1'b0;
              rd_st   <= R_IDLE;
            end else begin
              m_axiod <= buf_mem[rd_nx[AW-1:0]];
              rem     <= rem - LONE;
              m_last  <= rem == LTWO;
            end
          end
        end
        default: rd_st <= R_IDLE;
      endcase
    end
  end

`ifdef UDP_DISPATCH_STATS_EN
  logic inc_kill;
  logic inc_nm;
  logic inc_ovf;

  assign inc_kill = (wr_st == W_WAIT_KILL) && kill;
  assign inc_nm   = (wr_st == W_IDLE) && s_axiiv && !hit;
  assign inc_ovf  = ((wr_st == W_IDLE) && s_axiiv && hit &&
                     (meta_full || buf_full)) ||
                    ((wr_st == W_RECV) && s_axiiv && buf_full);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_kill_cnt    <= '0;
      drop_nomatch_cnt <= '0;
      drop_ovf_cnt     <= '0;
    end else begin
      if (inc_kill && drop_kill_cnt != 16'hFFFF)
        drop_kill_cnt <= drop_kill_cnt + 16'd1;
      if (inc_nm && drop_nomatch_cnt != 16'hFFFF)
        drop_nomatch_cnt <= drop_nomatch_cnt + 16'd1;
      if (inc_ovf && drop_ovf_cnt != 16'hFFFF)
        drop_ovf_cnt <= drop_ovf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_udp_rx_dispatch.sv
// Self-checking bench for udp_rx_dispatch (DEPTH=16, META_DEPTH=4)
// against a frame-level accept/drop model and an expected-beat queue.
module tb_udp_rx_dispatch;

  localparam int N  = 4;
  localparam int DP = 16;
  localparam int NP = 4;
  localparam int MD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_axiiv = 1'b0;
  logic [3:0]  s_axiid = '0;
  logic [15:0] dst_port_in = '0;
  logic        kill = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [15:0] cfg_port = '0;
  logic        cfg_en = 1'b0;
  logic        m_axiov;
  logic [3:0]  m_axiod;
  logic        m_last;
  logic [1:0]  m_idx;
  logic        m_axior = 1'b1;
  logic        busy;
`ifdef UDP_DISPATCH_STATS_EN
  logic [15:0] drop_kill_cnt;
  logic [15:0] drop_nomatch_cnt;
  logic [15:0] drop_ovf_cnt;
`endif

  always #5 clk = ~clk;

  udp_rx_dispatch #(
    .N(N), .DEPTH(DP), .NUM_PORTS(NP), .META_DEPTH(MD)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axiiv(s_axiiv), .s_axiid(s_axiid),
    .dst_port_in(dst_port_in), .kill(kill),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_port(cfg_port), .cfg_en(cfg_en),
    .m_axiov(m_axiov), .m_axiod(m_axiod),
    .m_last(m_last), .m_idx(m_idx),
    .m_axior(m_axior),
`ifdef UDP_DISPATCH_STATS_EN
    .drop_kill_cnt(drop_kill_cnt),
    .drop_nomatch_cnt(drop_nomatch_cnt),
    .drop_ovf_cnt(drop_ovf_cnt),
`endif
    .busy(busy)
  );

  int tests = 0;
  int fails = 0;
  logic [6:0]  expq [$];
  logic [6:0]  obsq [$];
  logic [15:0] mport [NP];
  bit          men [NP];
  int          pend_f = 0;
  int          pend_b = 0;

  always @(negedge clk)
    if (rst && m_axiov && m_axior)
      obsq.push_back({m_idx, m_last, m_axiod});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic int lookup(input logic [15:0] p);
    int r = -1;
    for (int i = NP - 1; i >= 0; i--)
      if (men[i] && mport[i] == p) r = i;
    return r;
  endfunction

  task automatic cfg(input int i, input logic [15:0] p, input bit e);
    cfg_we = 1'b1; cfg_idx = i[1:0]; cfg_port = p; cfg_en = e;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    mport[i] = p; men[i] = e;
  endtask

  task automatic send(input logic [15:0] p, input int len, input bit k);
    int idx = lookup(p);
    bit acc;
    logic [3:0] d;
    acc = idx >= 0 && !k && pend_f < MD && pend_b + len <= DP;
    for (int i = 0; i < len; i++) begin
      d = 4'($urandom);
      s_axiiv = 1'b1; s_axiid = d; dst_port_in = p;
      if (acc) expq.push_back({2'(idx), i == len - 1, d});
      @(posedge clk); #1;
    end
    s_axiiv = 1'b0;
    @(posedge clk); #1;
    kill = k;
    @(posedge clk); #1;
    kill = 1'b0;
    if (acc) begin pend_f++; pend_b += len; end
  endtask

  task automatic drain(input bit rnd, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      m_axior = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      if (obsq.size() >= expq.size() && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    m_axior = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    pend_f = 0; pend_b = 0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    tests++; if (m_axiov !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", m_axiov); end
    tests++; if (m_last !== 1'b0) begin fails++; $display("FAIL rst_last: got %b want 0", m_last); end
    tests++; if (m_axiod !== 4'h0) begin fails++; $display("FAIL rst_data: got %h want 0", m_axiod); end
    tests++; if (m_idx !== 2'd0) begin fails++; $display("FAIL rst_idx: got %0d want 0", m_idx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic;
    bit ok;
    cfg(1, 16'h1234, 1'b1);
    send(16'h1234, 12, 1'b0);
    drain(1'b0, ok);
    tests++;
    if (!ok || obsq.size() != 12 || expq.size() != 12) begin
      fails++; $display("FAIL basic_count: got %0d beats, want 12", obsq.size());
    end
    for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
      tests++;
      if (obsq[i] !== expq[i]) begin
        fails++; $display("FAIL basic_beat%0d: got %h want %h", i, obsq[i], expq[i]);
      end
    end
    obsq.delete(); expq.delete();
  endtask

  task automatic test_kill;
    bit ok;
    send(16'h1234, 12, 1'b1);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL kill_busy: got %b want 0", busy); end
    send(16'h1234, 12, 1'b0);
    drain(1'b0, ok);
    tests++;
    if (!ok || obsq.size() != expq.size()) begin
      fails++; $display("FAIL kill_count: got %0d beats, want %0d", obsq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
      tests++;
      if (obsq[i] !== expq[i]) begin
        fails++; $display("FAIL kill_beat%0d: got %h want %h", i, obsq[i], expq[i]);
      end
    end
    obsq.delete(); expq.delete();
  endtask

  task automatic test_nomatch;
    bit ok;
`ifdef UDP_DISPATCH_STATS_EN
    logic [15:0] nm0;
    nm0 = drop_nomatch_cnt;
`endif
    send(16'h9999, 6, 1'b0);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL nomatch_busy: got %b want 0", busy); end
    drain(1'b0, ok);
    tests++;
    if (!ok || obsq.size() != 0) begin
      fails++; $display("FAIL nomatch_out: got %0d beats, want 0", obsq.size());
    end
`ifdef UDP_DISPATCH_STATS_EN
    tests++;
    if (drop_nomatch_cnt !== nm0 + 16'd1) begin
      fails++; $display("FAIL nomatch_cnt: got %0d want %0d", drop_nomatch_cnt, nm0 + 16'd1);
    end
`endif
    obsq.delete(); expq.delete();
  endtask

  task automatic test_overflow;
    bit ok;
    send(16'h1234, 17, 1'b0);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ovf_busy: got %b want 0", busy); end
    send(16'h1234, 16, 1'b0);
    drain(1'b1, ok);
    tests++;
    if (!ok || obsq.size() != 16 || expq.size() != 16) begin
      fails++; $display("FAIL ovf_count: got %0d beats, want 16", obsq.size());
    end
    for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
      tests++;
      if (obsq[i] !== expq[i]) begin
        fails++; $display("FAIL ovf_beat%0d: got %h want %h", i, obsq[i], expq[i]);
      end
    end
    obsq.delete(); expq.delete();
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [6:0] first;
    m_axior = 1'b0;
    repeat (5) send(16'h1234, 4, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    first = expq[0];
    tests++; if (obsq.size() != 0) begin fails++; $display("FAIL b2b_hold: got %0d beats, want 0", obsq.size()); end
    tests++; if (m_axiov !== 1'b1) begin fails++; $display("FAIL b2b_valid: got %b want 1", m_axiov); end
    tests++; if (m_axiod !== first[3:0]) begin fails++; $display("FAIL b2b_stable: got %h want %h", m_axiod, first[3:0]); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy: got %b want 1", busy); end
    drain(1'b0, ok);
    tests++;
    if (!ok || obsq.size() != 16 || expq.size() != 16) begin
      fails++; $display("FAIL b2b_count: got %0d beats, want 16", obsq.size());
    end
    for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
      tests++;
      if (obsq[i] !== expq[i]) begin
        fails++; $display("FAIL b2b_beat%0d: got %h want %h", i, obsq[i], expq[i]);
      end
    end
    obsq.delete(); expq.delete();
  endtask

  task automatic test_random;
    bit ok;
    logic [15:0] p;
    for (int i = 0; i < NP; i++)
      cfg(i, 16'h1000 + 16'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0)
        cfg(int'($urandom_range(0, 3)), 16'h1000 + 16'($urandom_range(0, 5)),
            1'($urandom_range(0, 1)));
      p = 16'h1000 + 16'($urandom_range(0, 7));
      send(p, int'($urandom_range(1, 18)), $urandom_range(0, 3) == 0);
      drain(1'b1, ok);
      tests++;
      if (!ok || obsq.size() != expq.size()) begin
        fails++; $display("FAIL rand%0d_count: got %0d beats, want %0d", it, obsq.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
        tests++;
        if (obsq[i] !== expq[i]) begin
          fails++; $display("FAIL rand%0d_beat%0d: got %h want %h", it, i, obsq[i], expq[i]);
        end
      end
      obsq.delete(); expq.delete();
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    cfg(1, 16'h1234, 1'b1);
    m_axior = 1'b0;
    send(16'h1234, 8, 1'b0);
    @(posedge clk); #1;
    tests++; if (m_axiov !== 1'b1) begin fails++; $display("FAIL mid_valid: got %b want 1", m_axiov); end
    m_axior = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_axiiv = 1'b1; s_axiid = 4'($urandom); dst_port_in = 16'h1234;
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    obsq.delete(); expq.delete();
    tests++; if (m_axiov !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b want 0", m_axiov); end
    tests++; if (m_last !== 1'b0) begin fails++; $display("FAIL mid_rst_last: got %b want 0", m_last); end
    tests++; if (m_axiod !== 4'h0) begin fails++; $display("FAIL mid_rst_data: got %h want 0", m_axiod); end
    tests++; if (m_idx !== 2'd0) begin fails++; $display("FAIL mid_rst_idx: got %0d want 0", m_idx); end
    s_axiiv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < NP; i++) begin mport[i] = '0; men[i] = 1'b0; end
    pend_f = 0; pend_b = 0;
    repeat (30) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", busy); end
    tests++; if (obsq.size() != 0) begin fails++; $display("FAIL mid_stale: got %0d beats, want 0", obsq.size()); end
    send(16'h1234, 5, 1'b0);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_tbl_clear: got busy %b want 0", busy); end
    cfg(2, 16'h55AA, 1'b1);
    send(16'h55AA, 5, 1'b0);
    drain(1'b0, ok);
    tests++;
    if (!ok || obsq.size() != 5 || expq.size() != 5) begin
      fails++; $display("FAIL mid_after_count: got %0d beats, want 5", obsq.size());
    end
    for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
      tests++;
      if (obsq[i] !== expq[i]) begin
        fails++; $display("FAIL mid_after_beat%0d: got %h want %h", i, obsq[i], expq[i]);
      end
    end
    obsq.delete(); expq.delete();
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin mport[i] = '0; men[i] = 1'b0; end
    test_reset;
    test_basic;
    test_kill;
    test_nomatch;
    test_overflow;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
